// File: rtl/teras_job_ctrl.sv
// teras_job_ctrl: job sequencer between the bus-side word stream and the teras
// systolic datapath. A start command admits exactly n_in words into teras,
// captures exactly n_out results into a small FIFO, drains them to the
// consumer and then pulses done. Abort drops the job and flushes the FIFO.
module teras_job_ctrl #(
    parameter int DATA_W     = 32,
    parameter int CNT_W      = 16,
    parameter int FIFO_DEPTH = 8
) (
    input  logic              clk,
    input  logic              rst_n,

    input  logic              cfg_start_i,
    input  logic              cfg_abort_i,
    input  logic [CNT_W-1:0]  cfg_n_in_i,
    input  logic [CNT_W-1:0]  cfg_n_out_i,
    output logic              busy_o,
    output logic              done_o,
    output logic [CNT_W-1:0]  in_cnt_o,
    output logic [CNT_W-1:0]  out_cnt_o,

    input  logic              in_rts_i,
    output logic              in_rtr_o,
    input  logic [DATA_W-1:0] in_data_i,

    output logic              dp_rts_o,
    input  logic              dp_rtr_i,
    output logic [DATA_W-1:0] dp_data_o,

    input  logic              dp_rts_i,
    output logic              dp_rtr_o,
    input  logic [DATA_W-1:0] dp_data_i,

    output logic              out_rts_o,
    input  logic              out_rtr_i,
    output logic [DATA_W-1:0] out_data_o
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [PTR_W:0] FULL_LVL = (PTR_W + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t             state;
    logic               busy_q;
    logic               done_q;
    logic [CNT_W-1:0]   n_in_q;
    logic [CNT_W-1:0]   n_out_q;
    logic [CNT_W-1:0]   in_cnt_q;
    logic [CNT_W-1:0]   out_cnt_q;

    logic [DATA_W-1:0]  mem [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [PTR_W:0]     fill;

    logic               fifo_empty;
    logic               fifo_full;
    logic               in_gate;
    logic               in_xfer;
    logic               push;
    logic               pop;
    logic               abort;

    assign fifo_empty = (fill == '0);
    assign fifo_full  = (fill == FULL_LVL);

    // Abort only means something while a job is in flight.
    assign abort = cfg_abort_i && (state != ST_IDLE);

    // Input words flow straight through to teras, gated until n_in are admitted.
    assign in_gate   = (state == ST_LOAD) && (in_cnt_q < n_in_q);
    assign dp_data_o = in_data_i;
    assign dp_rts_o  = in_rts_i && in_gate;
    assign in_rtr_o  = dp_rtr_i && in_gate;
    assign in_xfer   = in_rts_i && in_rtr_o;

    // Results are accepted only while the job still wants them and there is room;
    // anything extra stays back-pressured in teras.
    assign dp_rtr_o = ((state == ST_LOAD) || (state == ST_DRAIN)) &&
                      !fifo_full && (out_cnt_q < n_out_q);
    assign push     = dp_rts_i && dp_rtr_o;

    // Consumer side reads the head entry; zero when empty so idle outputs are quiet.
    assign out_rts_o  = !fifo_empty;
    assign out_data_o = fifo_empty ? '0 : mem[rd_ptr];
    assign pop        = out_rts_o && out_rtr_i;

    assign busy_o    = busy_q;
    assign done_o    = done_q;
    assign in_cnt_o  = in_cnt_q;
    assign out_cnt_o = out_cnt_q;

    // Job FSM with its counters, latched job sizes and registered status flags.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            n_in_q    <= '0;
            n_out_q   <= '0;
            in_cnt_q  <= '0;
            out_cnt_q <= '0;
        end else if (abort) begin
            state     <= ST_IDLE;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            in_cnt_q  <= '0;
            out_cnt_q <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (cfg_start_i) begin
                        n_in_q    <= cfg_n_in_i;
                        n_out_q   <= cfg_n_out_i;
                        in_cnt_q  <= '0;
                        out_cnt_q <= '0;
                        busy_q    <= 1'b1;
                        state     <= (cfg_n_in_i != '0) ? ST_LOAD : ST_DRAIN;
                    end
                end
                ST_LOAD: begin
                    if (in_xfer)
                        in_cnt_q <= in_cnt_q + 1'b1;
                    if (push)
                        out_cnt_q <= out_cnt_q + 1'b1;
                    // The count reaching n_in is seen one cycle after the last word.
                    if (in_cnt_q == n_in_q)
                        state <= ST_DRAIN;
                end
                ST_DRAIN: begin
                    if (push)
                        out_cnt_q <= out_cnt_q + 1'b1;
                    if ((out_cnt_q == n_out_q) && fifo_empty) begin
                        state  <= ST_DONE;
                        done_q <= 1'b1;
                    end
                end
                ST_DONE: begin
                    state  <= ST_IDLE;
                    done_q <= 1'b0;
                    busy_q <= 1'b0;
                end
                default: begin
                    state  <= ST_IDLE;
                    done_q <= 1'b0;
                    busy_q <= 1'b0;
                end
            endcase
        end
    end

    // FIFO pointers and occupancy; abort flushes by resetting the pointers.
    always_ff @(posedge clk) begin
        if (!rst_n || abort) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            fill   <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   fill <= fill + 1'b1;
                2'b01:   fill <= fill - 1'b1;
                default: fill <= fill;
            endcase
        end
    end

    // FIFO storage; data needs no reset since it is only read when non-empty.
    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= dp_data_i;
    end

endmodule

// File: tb/tb_teras_job_ctrl.sv
// Bench for teras_job_ctrl: a queue-based job model predicts every output each
// cycle; directed scenarios add literal expectations, then random jobs follow.
module tb_teras_job_ctrl;

    localparam int DW    = 32;
    localparam int CW    = 16;
    localparam int DEPTH = 8;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          cfg_start_i, cfg_abort_i;
    logic [CW-1:0] cfg_n_in_i, cfg_n_out_i;
    logic          busy_o, done_o;
    logic [CW-1:0] in_cnt_o, out_cnt_o;
    logic          in_rts_i, in_rtr_o;
    logic [DW-1:0] in_data_i;
    logic          dp_rts_o, dp_rtr_i;
    logic [DW-1:0] dp_data_o;
    logic          dp_rts_i, dp_rtr_o;
    logic [DW-1:0] dp_data_i, dp_data_r;
    logic          out_rts_o, out_rtr_i;
    logic [DW-1:0] out_data_o;
    logic          seq_mode;

    always #5 clk = ~clk;

    // In sequence mode teras returns a word tagged with its own result index.
    assign dp_data_i = seq_mode ? (32'hB000_0000 | 32'(out_cnt_o)) : dp_data_r;

    teras_job_ctrl #(.DATA_W(DW), .CNT_W(CW), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n),
        .cfg_start_i(cfg_start_i), .cfg_abort_i(cfg_abort_i),
        .cfg_n_in_i(cfg_n_in_i), .cfg_n_out_i(cfg_n_out_i),
        .busy_o(busy_o), .done_o(done_o), .in_cnt_o(in_cnt_o), .out_cnt_o(out_cnt_o),
        .in_rts_i(in_rts_i), .in_rtr_o(in_rtr_o), .in_data_i(in_data_i),
        .dp_rts_o(dp_rts_o), .dp_rtr_i(dp_rtr_i), .dp_data_o(dp_data_o),
        .dp_rts_i(dp_rts_i), .dp_rtr_o(dp_rtr_o), .dp_data_i(dp_data_i),
        .out_rts_o(out_rts_o), .out_rtr_i(out_rtr_i), .out_data_o(out_data_o)
    );

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural job model ----------------
    // phase: 0 idle, 1 loading, 2 draining, 3 done
    int          m_ph;
    int unsigned m_nin, m_nout, m_ic, m_oc;
    logic [DW-1:0] q[$];
    bit          m_valid = 0;

    typedef struct {
        bit busy, done, in_rtr, dp_rts, dp_rtr, out_rts;
        logic [DW-1:0] dp_data, out_data;
        int unsigned ic, oc;
    } exp_t;

    function automatic exp_t calc();
        exp_t e;
        bit   open_in;
        open_in    = (m_ph == 1) && (m_ic < m_nin);
        e.dp_rts   = in_rts_i && open_in;
        e.in_rtr   = dp_rtr_i && open_in;
        e.dp_data  = in_data_i;
        e.dp_rtr   = (m_ph == 1 || m_ph == 2) && (q.size() < DEPTH) && (m_oc < m_nout);
        e.out_rts  = (q.size() > 0);
        e.out_data = e.out_rts ? q[0] : '0;
        e.busy     = (m_ph != 0);
        e.done     = (m_ph == 3);
        e.ic       = m_ic;
        e.oc       = m_oc;
        return e;
    endfunction

    always @(posedge clk) begin
        exp_t e;
        bit   was_empty;
        e = calc();
        was_empty = (q.size() == 0);
        if (!rst_n) begin
            m_valid = 1; m_ph = 0; m_nin = 0; m_nout = 0; m_ic = 0; m_oc = 0;
            q.delete();
        end else if (m_valid) begin
            if (cfg_abort_i && m_ph != 0) begin
                m_ph = 0; m_ic = 0; m_oc = 0; q.delete();
            end else begin
                if (e.out_rts && out_rtr_i) void'(q.pop_front());
                if (e.dp_rtr && dp_rts_i) begin q.push_back(dp_data_i); m_oc++; end
                if (e.in_rtr && in_rts_i) m_ic++;
                case (m_ph)
                    0: if (cfg_start_i) begin
                        m_nin = cfg_n_in_i; m_nout = cfg_n_out_i; m_ic = 0; m_oc = 0;
                        m_ph = (m_nin != 0) ? 1 : 2;
                    end
                    1: if (e.ic == m_nin) m_ph = 2;
                    2: if (e.oc == m_nout && was_empty) m_ph = 3;
                    default: m_ph = 0;
                endcase
            end
        end
    end

    // ---------------- per-cycle compare and event log ----------------
    int            cyc = 0;
    int            done_cnt = 0;
    int            last_done = -1;
    int            in_x = 0;
    logic [DW-1:0] got[$];

    always @(negedge clk) begin
        exp_t e;
        #2;
        cyc++;
        if (m_valid) begin
            e = calc();
            chk("busy_o",     64'(busy_o),     64'(e.busy));
            chk("done_o",     64'(done_o),     64'(e.done));
            chk("in_cnt_o",   64'(in_cnt_o),   64'(e.ic));
            chk("out_cnt_o",  64'(out_cnt_o),  64'(e.oc));
            chk("in_rtr_o",   64'(in_rtr_o),   64'(e.in_rtr));
            chk("dp_rts_o",   64'(dp_rts_o),   64'(e.dp_rts));
            chk("dp_data_o",  64'(dp_data_o),  64'(e.dp_data));
            chk("dp_rtr_o",   64'(dp_rtr_o),   64'(e.dp_rtr));
            chk("out_rts_o",  64'(out_rts_o),  64'(e.out_rts));
            chk("out_data_o", 64'(out_data_o), 64'(e.out_data));
        end
        if (out_rts_o === 1'b1 && out_rtr_i) got.push_back(out_data_o);
        if (done_o === 1'b1) begin done_cnt++; last_done = cyc; end
        if (in_rts_i && in_rtr_o === 1'b1) in_x++;
    end

    // ---------------- stimulus helpers ----------------
    task automatic idle_in();
        cfg_start_i = 0; cfg_abort_i = 0; cfg_n_in_i = '0; cfg_n_out_i = '0;
        in_rts_i = 0; in_data_i = '0; dp_rtr_i = 0; dp_rts_i = 0; dp_data_r = '0;
        out_rtr_i = 0;
    endtask

    task automatic wait_idle(input int maxc, input string nm);
        int n = 0;
        while (busy_o && n < maxc) begin @(negedge clk); n++; end
        chk(nm, 64'(busy_o), 64'd0);
    endtask

    task automatic clear_log();
        got.delete(); done_cnt = 0; in_x = 0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired at t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int s;
        seq_mode = 0;
        idle_in();
        rst_n = 0;
        repeat (2) @(negedge clk);
        rst_n = 1;
        @(negedge clk); #3;
        chk("rst busy", 64'(busy_o), 0);
        chk("rst out_rts", 64'(out_rts_o), 0);
        chk("rst in_cnt", 64'(in_cnt_o), 0);
        clear_log();

        // Job 1: 4 in, 2 out, two tagged results after the input phase.
        @(negedge clk);
        cfg_start_i = 1; cfg_n_in_i = 4; cfg_n_out_i = 2;
        in_rts_i = 1; in_data_i = $urandom; dp_rtr_i = 1; out_rtr_i = 1;
        @(negedge clk); cfg_start_i = 0;
        for (int i = 0; i < 20 && in_cnt_o != 4; i++) begin
            in_data_i = $urandom; @(negedge clk);
        end
        in_rts_i = 0; dp_rts_i = 1; dp_data_r = 32'hA5A5_0001;
        @(negedge clk); dp_data_r = 32'hA5A5_0002;
        @(negedge clk); dp_rts_i = 0;
        wait_idle(40, "job1 timeout");
        chk("job1 in_cnt", 64'(in_cnt_o), 4);
        chk("job1 nres", 64'(got.size()), 2);
        if (got.size() == 2) begin
            chk("job1 res0", 64'(got[0]), 64'h A5A5_0001);
            chk("job1 res1", 64'(got[1]), 64'h A5A5_0002);
        end
        chk("job1 done", 64'(done_cnt), 1);
        chk("job1 in_x", 64'(in_x), 4);
        idle_in(); clear_log();

        // Job 2: 10 results with the consumer stalled; FIFO fills to 8.
        @(negedge clk);
        seq_mode = 1;
        cfg_start_i = 1; cfg_n_in_i = 0; cfg_n_out_i = 10; dp_rts_i = 1;
        @(negedge clk); cfg_start_i = 0;
        repeat (15) @(negedge clk);
        #3;
        chk("full dp_rtr", 64'(dp_rtr_o), 0);
        chk("full out_cnt", 64'(out_cnt_o), 8);
        @(negedge clk); out_rtr_i = 1;
        wait_idle(60, "job2 timeout");
        dp_rts_i = 0; seq_mode = 0;
        chk("job2 nres", 64'(got.size()), 10);
        for (int k = 0; k < 10 && k < got.size(); k++)
            chk($sformatf("job2 res%0d", k), 64'(got[k]), 64'(32'hB000_0000 | k));
        chk("job2 done", 64'(done_cnt), 1);
        idle_in(); clear_log();

        // Job 3: n_in=3 while upstream keeps offering words.
        @(negedge clk);
        cfg_start_i = 1; cfg_n_in_i = 3; cfg_n_out_i = 0;
        in_rts_i = 1; dp_rtr_i = 1;
        @(negedge clk); cfg_start_i = 0;
        repeat (4) begin in_data_i = $urandom; @(negedge clk); end
        #3;
        chk("job3 in_rtr", 64'(in_rtr_o), 0);
        chk("job3 in_x", 64'(in_x), 3);
        wait_idle(20, "job3 timeout");
        chk("job3 in_cnt", 64'(in_cnt_o), 3);
        idle_in(); clear_log();

        // Job 4: abort mid-load with 3 words held in the FIFO.
        @(negedge clk);
        cfg_start_i = 1; cfg_n_in_i = 5; cfg_n_out_i = 6;
        @(negedge clk);
        cfg_start_i = 0; in_rts_i = 1; dp_rts_i = 1; dp_rtr_i = 1; dp_data_r = 32'h11;
        @(negedge clk); dp_data_r = 32'h22;
        @(negedge clk); in_rts_i = 0; dp_data_r = 32'h33;
        @(negedge clk); dp_rts_i = 0; cfg_abort_i = 1;
        #3;
        chk("pre-abort in_cnt", 64'(in_cnt_o), 2);
        chk("pre-abort out_cnt", 64'(out_cnt_o), 3);
        @(negedge clk); cfg_abort_i = 0;
        #3;
        chk("abort busy", 64'(busy_o), 0);
        chk("abort out_rts", 64'(out_rts_o), 0);
        chk("abort in_cnt", 64'(in_cnt_o), 0);
        chk("abort out_cnt", 64'(out_cnt_o), 0);
        chk("abort done", 64'(done_cnt), 0);
        @(negedge clk);
        cfg_start_i = 1; cfg_n_in_i = 2; cfg_n_out_i = 1;
        in_rts_i = 1; dp_rts_i = 1; out_rtr_i = 1;
        @(negedge clk); cfg_start_i = 0;
        wait_idle(30, "post-abort timeout");
        chk("post-abort done", 64'(done_cnt), 1);
        idle_in(); clear_log();

        // Job 5: reset in DRAIN with a start in the same cycle.
        @(negedge clk);
        cfg_start_i = 1; cfg_n_in_i = 0; cfg_n_out_i = 3; dp_rts_i = 1;
        @(negedge clk); cfg_start_i = 0;
        repeat (2) @(negedge clk);
        rst_n = 0; cfg_start_i = 1; dp_rts_i = 0;
        @(negedge clk); rst_n = 1; cfg_start_i = 0;
        #3;
        chk("rst2 busy", 64'(busy_o), 0);
        chk("rst2 done", 64'(done_o), 0);
        chk("rst2 cnts", 64'({in_cnt_o, out_cnt_o}), 0);
        chk("rst2 hs", 64'({in_rtr_o, dp_rts_o, dp_rtr_o, out_rts_o}), 0);
        chk("rst2 data", 64'({dp_data_o, out_data_o}), 0);
        @(negedge clk); #3;
        chk("rst2 start ignored", 64'(busy_o), 0);
        chk("rst2 no done", 64'(done_cnt), 0);
        idle_in(); clear_log();

        // Job 6: zero-length job, start pulsed again during DONE.
        @(negedge clk); cfg_start_i = 1;
        #3 s = cyc;
        @(negedge clk); cfg_start_i = 0;
        @(negedge clk); cfg_start_i = 1;
        @(negedge clk); cfg_start_i = 0;
        @(negedge clk); #3;
        chk("zero done cycle", 64'(last_done), 64'(s + 2));
        chk("zero done once", 64'(done_cnt), 1);
        chk("zero idle", 64'(busy_o), 0);
        idle_in(); clear_log();

        // Random jobs with random handshakes, rare aborts and resets.
        for (int j = 0; j < 40; j++) begin
            @(negedge clk);
            idle_in();
            cfg_start_i = 1;
            cfg_n_in_i  = CW'($urandom_range(0, 12));
            cfg_n_out_i = CW'($urandom_range(0, 12));
            @(negedge clk);
            cfg_start_i = 0;
            for (int c = 0; c < 300 && busy_o; c++) begin
                in_rts_i    = $urandom_range(0, 1);
                in_data_i   = $urandom;
                dp_rtr_i    = ($urandom_range(0, 3) != 0);
                dp_rts_i    = $urandom_range(0, 1);
                dp_data_r   = $urandom;
                out_rtr_i   = ($urandom_range(0, 9) < 7);
                cfg_abort_i = ($urandom_range(0, 79) == 0);
                cfg_start_i = ($urandom_range(0, 9) == 0);
                cfg_n_in_i  = CW'($urandom);
                rst_n       = ($urandom_range(0, 199) != 0);
                @(negedge clk);
                rst_n = 1; cfg_abort_i = 0; cfg_start_i = 0;
            end
            out_rtr_i = 1;
            wait_idle(20, "rand timeout");
            repeat (DEPTH + 1) @(negedge clk);
        end
        idle_in();
        repeat (3) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/teras_job_ctrl.md
Name: teras_job_ctrl

Overview:
- Job sequencer placed between the bus-side word stream and the teras systolic datapath.
- On a start command it admits exactly cfg_n_in words into teras over the rts/rtr handshake.
- It collects exactly cfg_n_out result words into an output FIFO, drains them to a consumer, then pulses done.
- It provides the job framing, back-pressure and abort that the raw datapath lacks.

Parameters:
- DATA_W, 32, width of every data word.
- CNT_W, 16, width of the job word counters.
- FIFO_DEPTH, 8, result FIFO entries; power of two, ≥2.

Ports:
- clk  in  1  single clock.
- rst_n  in  1  synchronous active-low reset.
- cfg_start_i  in  1  start pulse; sampled only in IDLE.
- cfg_abort_i  in  1  abort the current job.
- cfg_n_in_i  in  CNT_W  input words per job; latched on start.
- cfg_n_out_i  in  CNT_W  result words per job; latched on start.
- busy_o  out  1  high whenever the FSM is not in IDLE.
- done_o  out  1  one-cycle pulse at job end.
- in_cnt_o  out  CNT_W  input words accepted this job.
- out_cnt_o  out  CNT_W  result words captured this job.
- in_rts_i  in  1  upstream word valid.
- in_rtr_o  out  1  upstream ready.
- in_data_i  in  DATA_W  upstream word.
- dp_rts_o  out  1  word valid to teras.
- dp_rtr_i  in  1  teras ready.
- dp_data_o  out  DATA_W  word to teras.
- dp_rts_i  in  1  teras result valid.
- dp_rtr_o  out  1  ready to teras.
- dp_data_i  in  DATA_W  teras result.
- out_rts_o  out  1  result valid to consumer.
- out_rtr_i  in  1  consumer ready.
- out_data_o  out  DATA_W  result word.

Behaviour:
- Transfer rule: a word moves on any interface in the cycle where its rts and rtr are both high.
- Reset (rst_n=0 at a clk edge):
  - FSM goes to IDLE; counters, latched configs and FIFO pointers are cleared.
  - All outputs read 0 the following cycle.
  - Reset mid-job drops the job with no done pulse.
- FSM states: IDLE, LOAD, DRAIN, DONE.
  - IDLE: on cfg_start_i, latch n_in/n_out, clear counters, then go to LOAD if n_in≠0, else to DRAIN.
  - LOAD: go to DRAIN in the cycle after the in_cnt reaches n_in.
  - DRAIN: go to DONE when out_cnt==n_out and the FIFO is empty.
  - DONE: done_o=1 for exactly one cycle, then return to IDLE.
  - cfg_start_i outside IDLE is ignored.
- Input path (combinational pass-through, no storage):
  - dp_data_o = in_data_i.
  - Define gate = (state==LOAD) && (in_cnt<n_in).
  - dp_rts_o = in_rts_i && gate; in_rtr_o = dp_rtr_i && gate.
  - in_cnt increments on each transfer; it never exceeds n_in.
- Result path:
  - dp_rtr_o = (state is LOAD or DRAIN) && !fifo_full && (out_cnt<n_out).
  - Each dp transfer pushes dp_data_i into the FIFO and increments out_cnt.
  - Results arriving after n_out, or while in IDLE, are back-pressured, never dropped.
- FIFO:
  - Registered storage; out_rts_o = !empty and out_data_o = head entry.
  - A pushed word is visible on out_data_o no earlier than the next cycle (no bypass).
  - Simultaneous push and pop: both occur, occupancy unchanged.
  - Push is impossible when full because dp_rtr_o is low.
  - Pointers wrap modulo FIFO_DEPTH.
  - The FIFO pops in any state while non-empty.
- Abort: cfg_abort_i in LOAD/DRAIN/DONE causes, next cycle:
  - state = IDLE, FIFO flushed, counters cleared;
  - no done pulse.
  - Abort has priority over start and over every other transition in the same cycle.
  - Abort in IDLE has no effect.
- Zero-length job: n_in=0 and n_out=0 gives IDLE→DRAIN→DONE, with done_o 2 cycles after start.
- Counter arithmetic is unsigned CNT_W; the equality comparisons use the latched values.

Test Plan:
- n_in=4, n_out=2, all rtr=1, teras returns 2 words (0xA5A50001, 0xA5A50002) after input:
  - in_cnt_o reaches 4;
  - out_data_o emits both words in order;
  - done_o pulses once, 1 cycle after the FIFO empties;
  - busy_o then drops.
- out_rtr_i=0 while teras supplies 10 results with n_out=10, FIFO_DEPTH=8:
  - after 8 pushes dp_rtr_o=0;
  - releasing out_rtr_i drains all 10 in order, with no loss or duplication.
- n_in=3 with upstream offering 5 words:
  - exactly 3 transfers into teras;
  - in_rtr_o=0 from the 4th word onward;
  - remaining words are untouched.
- cfg_abort_i mid-LOAD (in_cnt=2) with 3 words in the FIFO:
  - next cycle busy_o=0, out_rts_o=0, counters 0;
  - no done_o pulse;
  - a new start then runs normally.
- rst_n=0 for 1 cycle during DRAIN:
  - all outputs 0 the following cycle;
  - cfg_start_i in the same cycle as reset is ignored.
- n_in=0, n_out=0: done_o high exactly 2 cycles after cfg_start_i; cfg_start_i asserted during DONE is ignored.
